// File: rtl/dec38_display_if.sv
// Code handshake between the 8-3 encoder output stage and the display decoder.
// The encoder side drives valid/code and watches ready.
interface dec38_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/dec38_display.sv
// One-deep buffered 3-to-8 display decoder: each accepted code is shown as a
// one-hot LED pattern and 7-seg digit for HOLD cycles, followed by GAP blanks.
module dec38_display #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  dec38_display_if.slave  in_if,
  input  logic            en,
  output logic [7:0]      out_onehot,
  output logic [6:0]      seg,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t     r_state, w_nxt_state;
  logic [7:0] r_cnt, w_nxt_cnt;
  logic [2:0] r_active, w_nxt_active;
  logic [2:0] r_pend;
  logic       r_pend_valid, w_nxt_pend_valid;
  logic       w_accept, w_take;

  function automatic logic [6:0] seg7(input logic [2:0] c);
    case (c)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  // Ready depends only on registered state, so a freed slot accepts one cycle later.
  assign in_if.in_ready   = !r_pend_valid && !rst;
  assign w_accept         = in_if.in_valid && in_if.in_ready;
  assign w_nxt_pend_valid = w_accept || (r_pend_valid && !w_take);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_active = r_active;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_valid) begin
          w_nxt_state  = S_SHOW;
          w_nxt_active = r_pend;
          w_nxt_cnt    = HOLD_M1;
          w_take       = 1'b1;
        end
      end
      S_SHOW: begin
        if (r_cnt != 8'd0) begin
          w_nxt_cnt = r_cnt - 8'd1;
        end else if (GAP > 0) begin
          w_nxt_state = S_GAP;
          w_nxt_cnt   = GAP_M1;
        end else if (r_pend_valid) begin
          w_nxt_active = r_pend;
          w_nxt_cnt    = HOLD_M1;
          w_take       = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt != 8'd0) begin
          w_nxt_cnt = r_cnt - 8'd1;
        end else if (r_pend_valid) begin
          w_nxt_state  = S_SHOW;
          w_nxt_active = r_pend;
          w_nxt_cnt    = HOLD_M1;
          w_take       = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Control and registered outputs; outputs are formed from next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_pend_valid <= 1'b0;
      out_onehot   <= 8'h00;
      seg          <= 7'h7f;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_pend_valid <= w_nxt_pend_valid;
      out_onehot   <= (w_nxt_state == S_SHOW && en) ? (8'b1 << w_nxt_active) : 8'h00;
      seg          <= (w_nxt_state == S_SHOW && en) ? seg7(w_nxt_active) : 7'h7f;
      busy         <= (w_nxt_state != S_IDLE) || w_nxt_pend_valid;
      done         <= (w_nxt_state == S_SHOW) && (w_nxt_cnt == 8'd0);
    end
  end

  // Code payload registers carry no reset; they are qualified by state/pend_valid.
  always_ff @(posedge clk) begin
    r_active <= w_nxt_active;
    if (w_accept) r_pend <= in_if.in_code;
  end
endmodule

// File: tb/tb_dec38_display.sv
// Bench for dec38_display: a HOLD=4/GAP=1 instance and a HOLD=4/GAP=0 instance,
// with done-triggered scoreboards and directed timing checks.
module tb_dec38_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1;
  always #5 clk = ~clk;

  dec38_display_if if_a();
  dec38_display_if if_b();

  logic [7:0] oh_a, oh_b;
  logic [6:0] sg_a, sg_b;
  logic       busy_a, busy_b, done_a, done_b;

  dec38_display #(.HOLD(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .in_if(if_a.slave), .en(en_a),
    .out_onehot(oh_a), .seg(sg_a), .busy(busy_a), .done(done_a));

  dec38_display #(.HOLD(4), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_if(if_b.slave), .en(en_b),
    .out_onehot(oh_b), .seg(sg_b), .busy(busy_b), .done(done_b));

  typedef struct {
    logic [7:0] oh;
    logic [6:0] sg;
    int         run;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: each done pulse pops the pattern expected for that code.
  logic [7:0] prev_a = 8'h00, prev_b = 8'h00;
  int         run_a = 0, run_b = 0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) begin
      prev_a = 8'h00; run_a = 0;
    end else begin
      if (oh_a == prev_a) run_a++; else run_a = 1;
      prev_a = oh_a;
      if (done_a) begin
        chk("a_done_expected", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          chk("a_onehot", oh_a, e.oh);
          chk("a_seg", sg_a, e.sg);
          if (e.run > 0) chk("a_hold_len", run_a, e.run);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) begin
      prev_b = 8'h00; run_b = 0;
    end else begin
      if (oh_b == prev_b) run_b++; else run_b = 1;
      prev_b = oh_b;
      if (done_b) begin
        chk("b_done_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          chk("b_onehot", oh_b, e.oh);
          chk("b_seg", sg_b, e.sg);
          if (e.run > 0) chk("b_hold_len", run_b, e.run);
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [2:0] c, input logic [7:0] oh,
                      input logic [6:0] sg, input int run);
    int   g = 0;
    exp_t e;
    if (sel) begin
      if_b.in_valid = 1'b1; if_b.in_code = c;
      while (!if_b.in_ready && g < 100) begin @(negedge clk); g++; end
    end else begin
      if_a.in_valid = 1'b1; if_a.in_code = c;
      while (!if_a.in_ready && g < 100) begin @(negedge clk); g++; end
    end
    chk("send_timeout", g < 100, 1);
    @(posedge clk); #1;
    e.oh = oh; e.sg = sg; e.run = run;
    if (sel) begin if_b.in_valid = 1'b0; q_b.push_back(e); end
    else     begin if_a.in_valid = 1'b0; q_a.push_back(e); end
  endtask

  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(sel ? done_b : done_a) && n < 50);
  endtask

  task automatic wait_idle(input bit sel);
    int g = 0;
    while ((sel ? busy_b : busy_a) && g < 100) begin @(negedge clk); g++; end
    chk("idle_timeout", g < 100, 1);
  endtask

  initial begin
    int n;
    if_a.in_valid = 1'b0; if_a.in_code = 3'd0;
    if_b.in_valid = 1'b0; if_b.in_code = 3'd0;

    // Reset values
    @(negedge clk);
    chk("rst_onehot", oh_a, 8'h00);
    chk("rst_seg", sg_a, 7'h7f);
    chk("rst_ready_a", if_a.in_ready, 0);
    chk("rst_ready_b", if_b.in_ready, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ready", if_a.in_ready, 1);
    chk("post_rst_busy", busy_a, 0);

    // Single code 5
    @(negedge clk);
    send(0, 3'd5, 8'h20, 7'h12, 4);
    chk("lat_still_blank", oh_a, 8'h00);
    chk("lat_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("lat_onehot", oh_a, 8'h20);
    chk("lat_seg", sg_a, 7'h12);
    wait_done(0, n);
    chk("code5_done_cycle", n, 3);
    @(posedge clk); #1;
    chk("gap_onehot", oh_a, 8'h00);
    chk("gap_seg", sg_a, 7'h7f);
    chk("gap_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("idle_busy", busy_a, 0);

    // Stream 3,7,0 with valid held high
    @(negedge clk);
    send(0, 3'd3, 8'h08, 7'h30, 4);
    send(0, 3'd7, 8'h80, 7'h78, 4);
    chk("ready_drops_full", if_a.in_ready, 0);
    send(0, 3'd0, 8'h01, 7'h40, 4);
    wait_idle(0);

    // GAP=0 back-to-back 1 then 2
    send(1, 3'd1, 8'h02, 7'h79, 4);
    send(1, 3'd2, 8'h04, 7'h24, 4);
    wait_done(1, n);
    chk("b_first_done_cycle", n, 2);
    @(posedge clk); #1;
    chk("b_contiguous", oh_b, 8'h04);
    chk("b_contig_seg", sg_b, 7'h24);
    wait_done(1, n);
    chk("b_second_done_cycle", n, 3);
    wait_idle(1);

    // en=0 during SHOW of code 6
    @(negedge clk);
    send(0, 3'd6, 8'h00, 7'h7f, 0);
    @(posedge clk); #1;
    chk("en1_onehot6", oh_a, 8'h40);
    chk("en1_seg6", sg_a, 7'h02);
    en_a = 1'b0;
    @(posedge clk); #1;
    chk("en0_onehot", oh_a, 8'h00);
    chk("en0_seg", sg_a, 7'h7f);
    wait_done(0, n);
    chk("en0_done_cycle", n, 2);
    en_a = 1'b1;
    wait_idle(0);

    // Reset mid-SHOW with a code pending
    @(negedge clk);
    send(0, 3'd4, 8'h10, 7'h19, 4);
    send(0, 3'd2, 8'h04, 7'h24, 4);
    chk("pre_rst_onehot", oh_a, 8'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    q_a.delete();
    q_b.delete();
    chk("mid_rst_onehot", oh_a, 8'h00);
    chk("mid_rst_seg", sg_a, 7'h7f);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", if_a.in_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("after_rst_ready", if_a.in_ready, 1);
    repeat (8) @(negedge clk);
    chk("dropped_onehot", oh_a, 8'h00);
    chk("dropped_busy", busy_a, 0);

    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
